pattern_gen_fifo: RTL
=====================

# pattern_gen_fifo

Parametrised test-pattern source that fills a downstream write FIFO for Ethernet datapath bring-up and loopback checks. After a fixed power-up settling delay it releases a downstream reset, then on command streams words from one of four pattern modes into the FIFO, throttled by the FIFO's programmable-full flag. Bursts are either a programmed length or continuous, and a wrapping word counter reports progress.

## Interface
- DATA_W, 32: width of generated data words.
- CNT_W, 16: width of burst length and word counter.
- STARTUP_CYC, 10: clocks from reset release to `reseto` assertion (1..2^16-1).

- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  level; 1 = run or arm, 0 = stop and return to idle.
- mode  in  2  00 increment, 01 decrement, 10 constant, 11 walking-one rotate-left.
- seed  in  DATA_W  first word of a burst.
- burst_len  in  CNT_W  words per burst; 0 = continuous.
- fifo_prog_full  in  1  FIFO programmable-full; FIFO threshold leaves ≥2 free entries.
- fifo_wr_en  out  1  registered FIFO write strobe.
- fifo_w_data  out  DATA_W  registered FIFO write data.
- reseto  out  1  downstream release; 1 once startup delay has elapsed.
- busy  out  1  1 while in RUN.
- done  out  1  1 after a finite burst completes, until `enable` drops.
- words_sent  out  CNT_W  words written since last IDLE→RUN, wraps at 2^CNT_W.

## Operation
- States: STARTUP, IDLE, RUN, DONE.
- Reset: state STARTUP, startup counter 0; all outputs 0 (`fifo_w_data` = 0, `reseto` = 0, `busy` = 0, `done` = 0, `words_sent` = 0).
- STARTUP: counter increments each clock; on the STARTUP_CYC-th rising edge with `reset` low, `reseto` ← 1 and state → IDLE. `reseto` stays 1 until next reset.
- IDLE: when `enable` = 1, latch `mode`, `seed`, `burst_len`; pattern register ← seed; remaining ← burst_len; `words_sent` ← 0; → RUN. Later changes to mode/seed/burst_len are ignored until next IDLE→RUN.
- RUN, per edge: if `enable` = 0 → IDLE (abort, `done` stays 0). Else if `fifo_prog_full` = 0 → write: `fifo_wr_en` ← 1, `fifo_w_data` ← pattern, pattern ← next(pattern), `words_sent` ← +1 (mod 2^CNT_W), remaining ← −1 (finite mode only). If remaining was 1 at that write → DONE. Else (`fifo_prog_full` = 1) `fifo_wr_en` ← 0, pattern held.
- Next-pattern: increment +1 mod 2^DATA_W; decrement −1 mod 2^DATA_W; constant unchanged; walking-one rotate left by 1, MSB wraps to bit 0. Walking-one with seed 0 loads 1 instead.
- DONE: `fifo_wr_en` 0, `done` 1; `enable` = 0 → IDLE (`done` ← 0). `enable` held 1 does not restart.
- `busy` = 1 exactly in RUN. `fifo_wr_en` 0 in every state except RUN.

## Timing
- `reseto` rises STARTUP_CYC clocks after the first edge with `reset` low.
- IDLE→RUN takes one edge; first possible `fifo_wr_en` on the following edge (2 clocks after `enable` seen high in IDLE).
- `fifo_prog_full` sampled at edge N gates the write issued at edge N; one word of latency after flag assertion is absorbed by FIFO slack.
- `enable` low sampled at edge N: no write at edge N; `fifo_wr_en` = 0 after N.
- Last burst word and DONE entry occur on the same edge; `fifo_wr_en` returns to 0 next edge.
- Reset mid-burst: all outputs 0 on that edge; startup delay restarts in full; `reseto` drops.
- `fifo_w_data` holds last written value while `fifo_wr_en` = 0.

## Test plan
- Startup: STARTUP_CYC=10, release reset → `reseto` 0 for edges 1–9, 1 at edge 10; `fifo_wr_en` 0 throughout with `enable` = 0.
- Increment burst: seed 0x0000_00FE, burst_len 4, prog_full 0 → writes 0xFE, 0xFF, 0x100, 0x101 on consecutive edges; `done` = 1, `words_sent` = 4, `busy` 0.
- Backpressure: increment, burst_len 6, prog_full high for 3 clocks after second word → data 0,1,(gap 3),2,3,4,5, no duplicate or skipped value.
- Walking-one/decrement: DATA_W=8, mode 11 seed 0x80 → 0x80, 0x01, 0x02; mode 01 seed 0x01 → 0x01, 0x00, 0xFF.
- Continuous + abort: burst_len 0, CNT_W=4, run 20 words → `words_sent` wraps to 4; drop `enable` → no write that edge, IDLE, `done` 0.
- Reset mid-run: assert reset during burst → outputs 0 next edge, `reseto` low again, re-rises after STARTUP_CYC.

Source files
------------

// File: rtl/pattern_gen_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pattern_gen_fifo
// Purpose  : Startup-delayed test-pattern source feeding a downstream write FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_gen_fifo #(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int STARTUP_CYC = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              fifo_prog_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_w_data,
    output logic              reseto,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  words_sent
);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [15:0] C_START_LAST = 16'(STARTUP_CYC - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [15:0]         r_start_cnt;
    logic [1:0]          r_mode;
    logic [DATA_W-1:0]   r_pattern;
    logic [DATA_W-1:0]   w_pattern_next;
    logic [DATA_W-1:0]   w_seed_load;
    logic [CNT_W-1:0]    r_remaining;
    logic                r_finite;
    logic                r_wr_en;
    logic [DATA_W-1:0]   r_w_data;
    logic                r_reseto;
    logic [CNT_W-1:0]    r_words;
    logic                w_write;
    logic                w_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_STARTUP;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_write      = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_STARTUP: begin
                if (r_start_cnt == C_START_LAST) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (enable) begin
                    w_load       = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    w_next_state = ST_IDLE;
                end else if (!fifo_prog_full) begin
                    w_write = 1'b1;
                    if (r_finite && (r_remaining == CNT_W'(1))) begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_STARTUP;
        endcase
    end

    // A walking-one pattern needs a set bit to walk, so a zero seed starts at 1.
    assign w_seed_load = ((mode == 2'b11) && (seed == '0)) ? DATA_W'(1) : seed;

    always_comb begin
        case (r_mode)
            2'b00:   w_pattern_next = r_pattern + DATA_W'(1);
            2'b01:   w_pattern_next = r_pattern - DATA_W'(1);
            2'b10:   w_pattern_next = r_pattern;
            default: w_pattern_next = {r_pattern[DATA_W-2:0], r_pattern[DATA_W-1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_cnt <= '0;
            r_mode      <= '0;
            r_pattern   <= '0;
            r_remaining <= '0;
            r_finite    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_w_data    <= '0;
            r_reseto    <= 1'b0;
            r_words     <= '0;
        end else begin
            r_wr_en <= w_write;
            if (r_state == ST_STARTUP) begin
                r_start_cnt <= r_start_cnt + 16'd1;
                if (r_start_cnt == C_START_LAST) begin
                    r_reseto <= 1'b1;
                end
            end
            if (w_load) begin
                r_mode      <= mode;
                r_pattern   <= w_seed_load;
                r_remaining <= burst_len;
                r_finite    <= |burst_len;
                r_words     <= '0;
            end
            // Remaining count only matters for finite bursts; continuous runs leave it alone.
            if (w_write) begin
                r_w_data  <= r_pattern;
                r_pattern <= w_pattern_next;
                r_words   <= r_words + CNT_W'(1);
                if (r_finite) begin
                    r_remaining <= r_remaining - CNT_W'(1);
                end
            end
        end
    end

    assign fifo_wr_en  = r_wr_en;
    assign fifo_w_data = r_w_data;
    assign reseto      = r_reseto;
    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign words_sent  = r_words;

endmodule
`default_nettype wire
